mmu_login_ctrl: RTL and testbench

- Sequencer that drives the `login` input of the memory-protection MMU.
- Grants a timed unlock session only after a processor writes a correct multi-word key sequence on a key port.
- Counts failed attempts and locks out further attempts for a fixed period after too many failures.
- Sits between the processor key-write path and the MMU; `login` is a registered output.

---
 rtl/mmu_pkg.sv | 21 ++
 rtl/mmu_down_timer.sv | 26 ++
 rtl/mmu_login_ctrl.sv | 146 ++++++++++++++
 tb/tb_mmu_login_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU login sequencer: state encoding, key words
// and the MMU address window.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    SESSION = 2'd2,
    LOCKED  = 2'd3
  } mmu_state_e;

  localparam logic [15:0] MMU_ADDR_LO = 16'h8000;
  localparam logic [15:0] MMU_ADDR_HI = 16'h8800;

  localparam logic [63:0] KEY_BASE = 64'h0000_0000_C0DE_0001;

  function automatic logic [63:0] key_word(input logic [1:0] i);
    return KEY_BASE + {62'd0, i};
  endfunction

endpackage

// File: rtl/mmu_down_timer.sv
// Loadable down-counter that stops at zero; shared by the gap, session
// and lockout timing.
module mmu_down_timer #(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mmu_login_ctrl.sv
// Key-sequence login sequencer for the MMU with failure lockout.
// Define MMU_VIOLATION_FAIL_EN to count mmu_protected hits as failures.
module mmu_login_ctrl
  import mmu_pkg::*;
#(
  parameter int KEY_LEN        = 4,
  parameter int SESSION_CYCLES = 1024,
  parameter int GAP_CYCLES     = 16,
  parameter int MAX_FAIL       = 3,
  parameter int LOCK_CYCLES    = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [63:0] key_data,
  input  logic        logout,
  input  logic        mmu_protected,
  output logic        login,
  output logic        locked,
  output logic [1:0]  fail_count,
  output logic        attempt_active
);

  localparam int TM0 = (SESSION_CYCLES > LOCK_CYCLES) ? SESSION_CYCLES : LOCK_CYCLES;
  localparam int TM1 = (TM0 > GAP_CYCLES) ? TM0 : GAP_CYCLES;
  localparam int TW  = $clog2(TM1 + 1);

  mmu_state_e r_state, w_state_nx;
  logic [1:0] r_idx, w_idx_nx;
  logic [1:0] r_fail, w_fail_nx;
  logic       r_login, r_locked, r_active;
  logic       w_load, w_tmr_zero, w_match, w_viol, w_fail_evt;
  logic [TW-1:0] w_load_val;

`ifdef MMU_VIOLATION_FAIL_EN
  assign w_viol = mmu_protected;
`else
  logic w_unused;
  assign w_unused = mmu_protected;
  assign w_viol   = 1'b0;
`endif

  assign w_match = (key_data == key_word(r_idx));

  mmu_down_timer #(.W(TW)) u_tmr (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .o_zero  (w_tmr_zero)
  );

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = '0;
    w_fail_nx  = r_fail;
    w_load     = 1'b0;
    w_load_val = '0;
    w_fail_evt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_viol || (key_valid && !w_match)) begin
          w_fail_evt = 1'b1;
        end else if (key_valid) begin
          if (KEY_LEN == 1) begin
            w_state_nx = SESSION;
            w_load     = 1'b1;
            w_load_val = TW'(SESSION_CYCLES - 1);
            w_fail_nx  = '0;
          end else begin
            w_state_nx = CHECK;
            w_idx_nx   = 2'd1;
            w_load     = 1'b1;
            w_load_val = TW'(GAP_CYCLES);
          end
        end
      end
      CHECK: begin
        if (w_viol || (key_valid && !w_match)) begin
          w_state_nx = IDLE;
          w_fail_evt = 1'b1;
        end else if (key_valid) begin
          w_load = 1'b1;
          if (r_idx == 2'(KEY_LEN - 1)) begin
            w_state_nx = SESSION;
            w_load_val = TW'(SESSION_CYCLES - 1);
            w_fail_nx  = '0;
          end else begin
            w_idx_nx   = r_idx + 2'd1;
            w_load_val = TW'(GAP_CYCLES);
          end
        end else if (w_tmr_zero) begin
          w_state_nx = IDLE;
          w_fail_evt = 1'b1;
        end else begin
          w_idx_nx = r_idx;
        end
      end
      SESSION: begin
        if (logout || w_tmr_zero)
          w_state_nx = IDLE;
      end
      LOCKED: begin
        if (w_tmr_zero) begin
          w_state_nx = IDLE;
          w_fail_nx  = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    // A failure that reaches the limit overrides the return to IDLE
    if (w_fail_evt) begin
      w_fail_nx = (r_fail == 2'(MAX_FAIL)) ? r_fail : r_fail + 2'd1;
      if (w_fail_nx == 2'(MAX_FAIL)) begin
        w_state_nx = LOCKED;
        w_idx_nx   = '0;
        w_load     = 1'b1;
        w_load_val = TW'(LOCK_CYCLES - 1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_fail   <= '0;
      r_login  <= 1'b0;
      r_locked <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_fail   <= w_fail_nx;
      r_login  <= (w_state_nx == SESSION);
      r_locked <= (w_state_nx == LOCKED);
      r_active <= (w_state_nx == CHECK);
    end
  end

  assign login          = r_login;
  assign locked         = r_locked;
  assign fail_count     = r_fail;
  assign attempt_active = r_active;

endmodule

// File: tb/tb_mmu_login_ctrl.sv
// Directed bench for mmu_login_ctrl with default parameters.
module tb_mmu_login_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [63:0] key_data = '0;
  logic        logout = 1'b0;
  logic        mmu_protected = 1'b0;
  logic        login, locked, attempt_active;
  logic [1:0]  fail_count;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] K1  = 64'h0000_0000_C0DE_0001;
  localparam logic [63:0] K2  = 64'h0000_0000_C0DE_0002;
  localparam logic [63:0] K3  = 64'h0000_0000_C0DE_0003;
  localparam logic [63:0] K4  = 64'h0000_0000_C0DE_0004;
  localparam logic [63:0] BAD = 64'h0000_0000_C0DE_0009;

  mmu_login_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .key_valid      (key_valid),
    .key_data       (key_data),
    .logout         (logout),
    .mmu_protected  (mmu_protected),
    .login          (login),
    .locked         (locked),
    .fail_count     (fail_count),
    .attempt_active (attempt_active)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] d);
    key_valid = 1'b1;
    key_data  = d;
    @(negedge clock);
    key_valid = 1'b0;
    key_data  = '0;
  endtask

  task automatic full_key();
    send(K1); send(K2); send(K3); send(K4);
  endtask

  task automatic do_logout();
    logout = 1'b1;
    @(negedge clock);
    logout = 1'b0;
  endtask

  int cnt;
  logic seen;

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_login", login, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_active", attempt_active, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Good key, session length
    send(K1);
    chk("w1_active", attempt_active, 1);
    send(K2); send(K3);
    chk("w3_login", login, 0);
    send(K4);
    chk("w4_login", login, 1);
    chk("w4_active", attempt_active, 0);
    chk("w4_fail", fail_count, 0);
    cnt = 0;
    while (login && cnt < 2000) begin
      cnt++;
      @(negedge clock);
    end
    chk("sess_len", cnt, 1024);
    chk("sess_end_login", login, 0);

    // Mismatch in CHECK
    send(K1); send(K2); send(BAD);
    chk("bad_fail", fail_count, 1);
    chk("bad_active", attempt_active, 0);
    chk("bad_login", login, 0);

    // Lockout
    send(BAD);
    chk("bad2_fail", fail_count, 2);
    chk("bad2_locked", locked, 0);
    send(BAD);
    chk("lock_on", locked, 1);
    chk("lock_fail", fail_count, 3);
    cnt  = 0;
    seen = 1'b0;
    while (locked && cnt < 9000) begin
      if (cnt >= 10 && cnt <= 13) begin
        key_valid = 1'b1;
        key_data  = K1 + 64'(cnt - 10);
      end else begin
        key_valid = 1'b0;
        key_data  = '0;
      end
      if (login) seen = 1'b1;
      cnt++;
      @(negedge clock);
    end
    key_valid = 1'b0;
    chk("lock_len", cnt, 4096);
    chk("lock_no_login", seen, 0);
    chk("lock_end_fail", fail_count, 0);
    full_key();
    chk("post_lock_login", login, 1);

    // Logout at session cycle 10
    repeat (9) @(negedge clock);
    chk("c10_login", login, 1);
    do_logout();
    chk("c11_login", login, 0);
    @(negedge clock);
    chk("c12_login", login, 0);

    // Logout together with timeout
    full_key();
    repeat (1023) @(negedge clock);
    chk("c1024_login", login, 1);
    do_logout();
    chk("lo_to_login", login, 0);
    chk("lo_to_locked", locked, 0);
    chk("lo_to_fail", fail_count, 0);
    full_key();
    chk("relogin", login, 1);
    do_logout();

    // Logout outside SESSION is ignored
    send(K1);
    do_logout();
    chk("lo_check_active", attempt_active, 1);
    send(K2); send(K3); send(K4);
    chk("lo_check_login", login, 1);
    do_logout();

    // Gap timeout
    send(K1);
    repeat (16) @(negedge clock);
    chk("gap16_active", attempt_active, 1);
    @(negedge clock);
    chk("gap17_active", attempt_active, 0);
    chk("gap17_fail", fail_count, 1);
    send(K1);
    repeat (16) @(negedge clock);
    send(K2); send(K3); send(K4);
    chk("gap_ok_login", login, 1);
    chk("gap_ok_fail", fail_count, 0);

    // Async reset mid-session
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk("async_login", login, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_login", login, 0);

    // mmu_protected in IDLE
    mmu_protected = 1'b1;
    repeat (3) @(negedge clock);
    mmu_protected = 1'b0;
`ifdef MMU_VIOLATION_FAIL_EN
    chk("viol_locked", locked, 1);
    chk("viol_fail", fail_count, 3);
`else
    chk("viol_locked", locked, 0);
    chk("viol_fail", fail_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
